// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter and single-transaction sequencer for the peripheral bus.
// Optional hung-slave timeout is built when SOC_BUS_ARB_TIMEOUT_EN is defined.
module soc_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_valid,
  output logic [2:0]  s_sel,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_we,
  output logic [3:0]  s_wstrb,
  input  logic [2:0]  s_ready,
  input  logic [31:0] s_rdata_mem,
  input  logic [31:0] s_rdata_gpio,
  input  logic [31:0] s_rdata_i2c
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("soc_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_last_q, rr_last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        gnt_m1;
  logic [2:0]  dec_sel;
  logic [31:0] slave_rdata;
`ifdef SOC_BUS_ARB_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
`endif

  function automatic logic [2:0] decode_sel(input logic [31:0] a);
    case (a[31:28])
      4'h0:    decode_sel = 3'b001;
      4'h4:    decode_sel = 3'b010;
      4'h5:    decode_sel = 3'b100;
      default: decode_sel = 3'b000;
    endcase
  endfunction

  always_comb begin
    case (sel_q)
      3'b001:  slave_rdata = s_rdata_mem;
      3'b010:  slave_rdata = s_rdata_gpio;
      3'b100:  slave_rdata = s_rdata_i2c;
      default: slave_rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_m1    = 1'b0;
    dec_sel   = 3'b000;
`ifdef SOC_BUS_ARB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          // Under contention the master not served last wins.
          gnt_m1  = (m0_req && m1_req) ? ~rr_last_q : m1_req;
          owner_d = gnt_m1;
          addr_d  = gnt_m1 ? m1_addr  : m0_addr;
          wdata_d = gnt_m1 ? m1_wdata : m0_wdata;
          we_d    = gnt_m1 ? m1_we    : m0_we;
          wstrb_d = gnt_m1 ? m1_wstrb : m0_wstrb;
          dec_sel = decode_sel(addr_d);
          sel_d   = dec_sel;
          if (dec_sel == 3'b000) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_XFER;
`ifdef SOC_BUS_ARB_TIMEOUT_EN
            tmo_d   = 16'd0;
`endif
          end
        end
      end
      ST_XFER: begin
        if ((s_ready & sel_q) != 3'b000) begin
          rdata_d = we_q ? 32'h0 : slave_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
`ifdef SOC_BUS_ARB_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        rr_last_d = owner_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      wstrb_q   <= 4'h0;
      sel_q     <= 3'b000;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      wstrb_q   <= wstrb_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef SOC_BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= 16'd0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign s_valid  = (state_q == ST_XFER);
  assign s_sel    = sel_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_we     = we_q;
  assign s_wstrb  = wstrb_q;

  // Response fields are only driven alongside the owner's ready pulse.
  assign m0_ready = (state_q == ST_RESP) && !owner_q;
  assign m1_ready = (state_q == ST_RESP) &&  owner_q;
  assign m0_rdata = m0_ready ? rdata_q : 32'h0;
  assign m1_rdata = m1_ready ? rdata_q : 32'h0;
  assign m0_err   = m0_ready & err_q;
  assign m1_err   = m1_ready & err_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Testbench for soc_bus_arbiter: directed scenarios plus a randomized contention run
// checked against a transaction-level timing/data model.
module tb_soc_bus_arbiter;
  localparam int TO = 8;
  localparam int NTX = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_we;
  logic [2:0]  s_sel, s_ready;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata_mem, s_rdata_gpio, s_rdata_i2c;

  logic        auto_en = 1'b0;
  logic [2:0]  auto_ready = 3'b000;
  logic [2:0]  man_ready = 3'b000;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  int          xcnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  soc_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
    .s_wstrb(s_wstrb), .s_ready(s_ready),
    .s_rdata_mem(s_rdata_mem), .s_rdata_gpio(s_rdata_gpio), .s_rdata_i2c(s_rdata_i2c)
  );

  // Slave models: read data is a fixed function of the presented address.
  assign s_rdata_mem  = ovr_en ? ovr_data : (s_addr ^ 32'hA5A5_0000);
  assign s_rdata_gpio = s_addr ^ 32'h0F0F_1234;
  assign s_rdata_i2c  = ~s_addr;
  assign s_ready      = auto_en ? auto_ready : man_ready;

  // Auto responder: latency addr[2:0] cycles, never responds when addr[8] is set.
  always @(negedge clk) begin
    if (s_valid) begin
      if (!s_addr[8] && xcnt == int'(s_addr[2:0])) auto_ready = s_sel | (3'($urandom) & ~s_sel);
      else                                          auto_ready = 3'($urandom) & ~s_sel;
      xcnt++;
    end else begin
      xcnt = 0;
      auto_ready = 3'($urandom);
    end
  end

  function automatic logic [2:0] region(input logic [31:0] a);
    if (a[31:28] == 4'h0)      return 3'b001;
    else if (a[31:28] == 4'h4) return 3'b010;
    else if (a[31:28] == 4'h5) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a[31:28] == 4'h0)      return a ^ 32'hA5A5_0000;
    else if (a[31:28] == 4'h4) return a ^ 32'h0F0F_1234;
    return ~a;
  endfunction

  task automatic new_req(input bit m);
    logic [31:0] a;
    int r;
    r = $urandom_range(0, 9);
    a = $urandom;
    if (r < 4)      a[31:28] = 4'h0;
    else if (r < 6) a[31:28] = 4'h4;
    else if (r < 8) a[31:28] = 4'h5;
    else            a[31:28] = 4'h6 + 4'($urandom_range(0, 9));
`ifdef SOC_BUS_ARB_TIMEOUT_EN
    a[8] = ($urandom_range(0, 7) == 0);
`else
    a[8] = 1'b0;
`endif
    if (m) begin
      m1_addr = a; m1_we = 1'($urandom); m1_wdata = $urandom; m1_wstrb = 4'($urandom);
    end else begin
      m0_addr = a; m0_we = 1'($urandom); m0_wdata = $urandom; m0_wstrb = 4'($urandom);
    end
  endtask

  task automatic test_reset;
    m0_req = 0; m1_req = 0; rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_valid, s_sel, s_addr, s_wdata, s_we, s_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata, m0_err, m1_err} !== '0) begin
      failures++; $display("FAIL reset_outputs got s_valid=%b s_sel=%b s_addr=%h m0_ready=%b m1_ready=%b required all zero", s_valid, s_sel, s_addr, m0_ready, m1_ready);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin
      failures++; $display("FAIL reset_idle got valid/rdy0/rdy1=%b%b%b required 000", s_valid, m0_ready, m1_ready);
    end
  endtask

  task automatic test_single_read;
    ovr_en = 1; ovr_data = 32'hDEAD_BEEF; man_ready = 3'b001;
    m0_req = 1; m0_addr = 32'h0000_0010; m0_we = 0; m0_wdata = $urandom; m0_wstrb = 4'h0;
    @(negedge clk);
    checks++;
    if ({s_valid, s_sel, m0_ready} !== 5'b1_001_0) begin
      failures++; $display("FAIL single_xfer got valid=%b sel=%b rdy=%b required 1 001 0", s_valid, s_sel, m0_ready);
    end
    checks++;
    if (s_addr !== 32'h0000_0010) begin
      failures++; $display("FAIL single_addr got %h required 00000010", s_addr);
    end
    @(negedge clk);
    checks++;
    if ({m0_ready, m0_err, m1_ready, s_valid} !== 4'b1000) begin
      failures++; $display("FAIL single_resp got rdy=%b err=%b rdy1=%b valid=%b required 1 0 0 0", m0_ready, m0_err, m1_ready, s_valid);
    end
    checks++;
    if (m0_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL single_rdata got %h required deadbeef", m0_rdata);
    end
    m0_req = 0; man_ready = 3'b000;
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b0) begin
      failures++; $display("FAIL single_pulse got rdy=%b required 0", m0_ready);
    end
    ovr_en = 0;
  endtask

  task automatic test_unmapped;
    m1_req = 1; m1_addr = 32'h8000_0000; m1_we = 1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    @(negedge clk);
    checks++;
    if ({m1_ready, m1_err, s_valid, m0_ready} !== 4'b1100) begin
      failures++; $display("FAIL unmapped_resp got rdy=%b err=%b valid=%b rdy0=%b required 1 1 0 0", m1_ready, m1_err, s_valid, m0_ready);
    end
    checks++;
    if (m1_rdata !== 32'h0) begin
      failures++; $display("FAIL unmapped_rdata got %h required 0", m1_rdata);
    end
    m1_req = 0;
    @(negedge clk);
    checks++;
    if ({m1_ready, s_valid} !== 2'b00) begin
      failures++; $display("FAIL unmapped_after got rdy=%b valid=%b required 00", m1_ready, s_valid);
    end
  endtask

`ifdef SOC_BUS_ARB_TIMEOUT_EN
  task automatic test_timeout;
    for (int pass = 0; pass < 2; pass++) begin
      man_ready = 3'b101;
      m0_req = 1; m0_addr = 32'h4000_0000; m0_we = 0;
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        checks++;
        if ({s_valid, m0_ready} !== 2'b10) begin
          failures++; $display("FAIL tmo_hold pass=%0d cyc=%0d got valid=%b rdy=%b required 1 0", pass, k, s_valid, m0_ready);
        end
        if (pass == 1 && k == TO) man_ready = 3'b010;
      end
      @(negedge clk);
      checks++;
      if ({m0_ready, m0_err} !== {1'b1, pass == 0}) begin
        failures++; $display("FAIL tmo_resp pass=%0d got rdy=%b err=%b required 1 %b", pass, m0_ready, m0_err, pass == 0);
      end
      checks++;
      if (m0_rdata !== (pass == 0 ? 32'h0 : 32'h4F0F_1234)) begin
        failures++; $display("FAIL tmo_rdata pass=%0d got %h", pass, m0_rdata);
      end
      m0_req = 0; man_ready = 3'b000;
      @(negedge clk);
    end
  endtask
`else
  task automatic test_no_timeout;
    int bad;
    bad = 0;
    man_ready = 3'b101;
    m0_req = 1; m0_addr = 32'h4000_0000; m0_we = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      checks++;
      if ({s_valid, m0_ready} !== 2'b10) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL notmo_hold cyc=%0d got valid=%b rdy=%b required 1 0", k, s_valid, m0_ready);
      end
    end
    man_ready = 3'b010;
    @(negedge clk);
    checks++;
    if ({m0_ready, m0_err} !== 2'b10) begin
      failures++; $display("FAIL notmo_resp got rdy=%b err=%b required 1 0", m0_ready, m0_err);
    end
    checks++;
    if (m0_rdata !== 32'h4F0F_1234) begin
      failures++; $display("FAIL notmo_rdata got %h required 4f0f1234", m0_rdata);
    end
    m0_req = 0; man_ready = 3'b000;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    man_ready = 3'b000;
    m0_req = 1; m0_addr = 32'h5000_0000; m0_we = 0;
    @(negedge clk);
    checks++;
    if ({s_valid, s_sel} !== 4'b1_100) begin
      failures++; $display("FAIL rstmid_xfer got valid=%b sel=%b required 1 100", s_valid, s_sel);
    end
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({s_valid, s_sel, s_addr, s_wdata, s_we, s_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata, m0_err, m1_err} !== '0) begin
      failures++; $display("FAIL rstmid_outputs got valid=%b sel=%b addr=%h rdy=%b%b required all zero", s_valid, s_sel, s_addr, m0_ready, m1_ready);
    end
    rst_n = 1; man_ready = 3'b001;
    m0_addr = 32'h0000_0040; m1_req = 1; m1_addr = 32'h0000_0080; m1_we = 0;
    @(negedge clk);
    checks++;
    if (s_addr !== 32'h0000_0040) begin
      failures++; $display("FAIL rstmid_first_grant got addr=%h required 00000040", s_addr);
    end
    @(negedge clk);
    checks++;
    if ({m0_ready, m1_ready} !== 2'b10 || m0_rdata !== 32'hA5A5_0040) begin
      failures++; $display("FAIL rstmid_resp got rdy=%b%b rdata=%h required 10 a5a50040", m0_ready, m1_ready, m0_rdata);
    end
    m0_req = 0; m1_req = 0; man_ready = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_contention_random;
    int idle_cyc, exp_rdy, ntx, bad, cyc;
    bit exp_owner, exp_err, mapped, hang;
    logic [31:0] ea, ewd, erd;
    logic        ewe;
    logic [3:0]  ews;
    logic [2:0]  esel;
    new_req(0); new_req(1);
    m0_req = 1; m1_req = 1; rst_n = 0; auto_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle_cyc = 0; exp_rdy = -1; ntx = 0; bad = 0; exp_owner = 0; mapped = 0;
    ea = 0; ewd = 0; erd = 0; ewe = 0; ews = 0; esel = 0; exp_err = 0;
    for (cyc = 0; cyc < 4000 && ntx < NTX; cyc++) begin
      if (cyc == idle_cyc) begin
        ea   = exp_owner ? m1_addr  : m0_addr;
        ewe  = exp_owner ? m1_we    : m0_we;
        ewd  = exp_owner ? m1_wdata : m0_wdata;
        ews  = exp_owner ? m1_wstrb : m0_wstrb;
        esel = region(ea);
        mapped = (esel != 3'b000);
        hang = mapped && ea[8];
        if (!mapped) begin
          exp_rdy = cyc + 1; exp_err = 1; erd = 0;
        end else if (hang) begin
          exp_rdy = cyc + TO + 1; exp_err = 1; erd = 0;
        end else begin
          exp_rdy = cyc + int'(ea[2:0]) + 2; exp_err = 0; erd = ewe ? 32'h0 : slave_data(ea);
        end
      end
      checks++;
      if ({m0_ready, m1_ready} !== {cyc == exp_rdy && !exp_owner, cyc == exp_rdy && exp_owner}) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rnd_ready cyc=%0d got %b%b required %b%b", cyc, m0_ready, m1_ready, cyc == exp_rdy && !exp_owner, cyc == exp_rdy && exp_owner);
      end
      checks++;
      if (s_valid !== (mapped && cyc > idle_cyc && cyc < exp_rdy)) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rnd_valid cyc=%0d got %b required %b", cyc, s_valid, mapped && cyc > idle_cyc && cyc < exp_rdy);
      end
      if (mapped && cyc > idle_cyc && cyc < exp_rdy) begin
        checks++;
        if ({s_sel, s_addr, s_we, s_wdata, s_wstrb} !== {esel, ea, ewe, ewd, ews}) begin
          failures++; bad++;
          if (bad < 10) $display("FAIL rnd_fields cyc=%0d got sel=%b addr=%h we=%b required sel=%b addr=%h we=%b", cyc, s_sel, s_addr, s_we, esel, ea, ewe);
        end
      end
      if (cyc == exp_rdy) begin
        checks++;
        if ((exp_owner ? {m1_rdata, m1_err} : {m0_rdata, m0_err}) !== {erd, exp_err}) begin
          failures++; bad++;
          if (bad < 10) $display("FAIL rnd_resp m%0d addr=%h got rdata=%h err=%b required rdata=%h err=%b", exp_owner, ea,
                                 exp_owner ? m1_rdata : m0_rdata, exp_owner ? m1_err : m0_err, erd, exp_err);
        end
        new_req(exp_owner);
        ntx++;
        idle_cyc = cyc + 1;
        exp_owner = ~exp_owner;
        mapped = 0;
        if (ntx == NTX) begin
          m0_req = 0; m1_req = 0;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ntx != NTX) begin
      failures++; $display("FAIL rnd_budget completed=%0d required %0d", ntx, NTX);
    end
    m0_req = 0; m1_req = 0; auto_en = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_unmapped();
`ifdef SOC_BUS_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    test_contention_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
